// File: rtl/miriscv_rvfi_tracer.sv
// RVFI retirement tracer: formats writeback events into a DEPTH-entry FIFO, order-numbered, one in / one out per cycle.
// Latency one cycle from retire to rvfi_valid_o; a stalled sink holds the head stable, and events arriving when full are dropped (sticky overflow_o).
module miriscv_rvfi_tracer #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) (
    input  logic                         clk_i,
    input  logic                         aresetn_i,
    input  logic                         ret_valid_i,
    input  logic [31:0]                  ret_insn_i,
    input  logic [XLEN-1:0]              ret_pc_rdata_i,
    input  logic [XLEN-1:0]              ret_pc_wdata_i,
    input  logic                         ret_rs1_used_i,
    input  logic                         ret_rs2_used_i,
    input  logic [4:0]                   ret_rs1_addr_i,
    input  logic [4:0]                   ret_rs2_addr_i,
    input  logic [XLEN-1:0]              ret_rs1_rdata_i,
    input  logic [XLEN-1:0]              ret_rs2_rdata_i,
    input  logic                         ret_rd_we_i,
    input  logic [4:0]                   ret_rd_addr_i,
    input  logic [XLEN-1:0]              ret_rd_wdata_i,
    input  logic                         ret_mem_req_i,
    input  logic                         ret_mem_we_i,
    input  logic [2:0]                   ret_mem_size_i,
    input  logic [XLEN-1:0]              ret_mem_addr_i,
    input  logic [XLEN-1:0]              ret_mem_wdata_i,
    input  logic [XLEN-1:0]              ret_mem_rdata_i,
    input  logic                         ret_trap_i,
    input  logic                         ret_intr_i,
    input  logic                         rvfi_ready_i,
    output logic                         rvfi_valid_o,
    output logic [ORDER_W-1:0]           rvfi_order_o,
    output logic [31:0]                  rvfi_insn_o,
    output logic                         rvfi_trap_o,
    output logic                         rvfi_halt_o,
    output logic                         rvfi_intr_o,
    output logic [1:0]                   rvfi_mode_o,
    output logic [1:0]                   rvfi_ixl_o,
    output logic [4:0]                   rvfi_rs1_addr_o,
    output logic [4:0]                   rvfi_rs2_addr_o,
    output logic [XLEN-1:0]              rvfi_rs1_rdata_o,
    output logic [XLEN-1:0]              rvfi_rs2_rdata_o,
    output logic [4:0]                   rvfi_rd_addr_o,
    output logic [XLEN-1:0]              rvfi_rd_wdata_o,
    output logic [XLEN-1:0]              rvfi_pc_rdata_o,
    output logic [XLEN-1:0]              rvfi_pc_wdata_o,
    output logic [XLEN-1:0]              rvfi_mem_addr_o,
    output logic [3:0]                   rvfi_mem_rmask_o,
    output logic [3:0]                   rvfi_mem_wmask_o,
    output logic [XLEN-1:0]              rvfi_mem_rdata_o,
    output logic [XLEN-1:0]              rvfi_mem_wdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    // miriscv_decode_pkg MEM_ACCESS_* encodings
    localparam logic [2:0] MEM_ACCESS_WORD  = 3'd0;
    localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
    localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd2;
    localparam logic [2:0] MEM_ACCESS_UHALF = 3'd4;
    localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd5;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [31:0]        insn;
        logic               trap;
        logic               intr;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [XLEN-1:0]    rs1_rdata;
        logic [XLEN-1:0]    rs2_rdata;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    rd_wdata;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [XLEN-1:0]    mem_addr;
        logic [3:0]         mem_rmask;
        logic [3:0]         mem_wmask;
        logic [XLEN-1:0]    mem_rdata;
        logic [XLEN-1:0]    mem_wdata;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [ORDER_W-1:0] r_order;
    logic               r_overflow;

    logic   w_empty;
    logic   w_full;
    logic   w_push;
    logic   w_pop;
    logic   w_drop;
    logic   [3:0] w_base_mask;
    logic   [3:0] w_lane_mask;
    entry_t w_entry;
    entry_t w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && rvfi_ready_i;
    assign w_push  = ret_valid_i && (!w_full || w_pop);
    assign w_drop  = ret_valid_i && w_full && !w_pop;

    always_comb begin
        w_base_mask = 4'b0000;
        case (ret_mem_size_i)
            MEM_ACCESS_WORD:                   w_base_mask = 4'b1111;
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: w_base_mask = 4'b0011;
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: w_base_mask = 4'b0001;
            default:                           w_base_mask = 4'b0000;
        endcase
    end

    // Misaligned accesses simply lose the lanes shifted past bit 3.
    assign w_lane_mask = w_base_mask << ret_mem_addr_i[1:0];

    always_comb begin
        w_entry          = '0;
        w_entry.order    = r_order;
        w_entry.insn     = ret_insn_i;
        w_entry.trap     = ret_trap_i;
        w_entry.intr     = ret_intr_i;
        w_entry.pc_rdata = ret_pc_rdata_i;
        w_entry.pc_wdata = ret_pc_wdata_i;
        if (ret_rs1_used_i) begin
            w_entry.rs1_addr  = ret_rs1_addr_i;
            w_entry.rs1_rdata = ret_rs1_rdata_i;
        end
        if (ret_rs2_used_i) begin
            w_entry.rs2_addr  = ret_rs2_addr_i;
            w_entry.rs2_rdata = ret_rs2_rdata_i;
        end
        if (ret_rd_we_i && (ret_rd_addr_i != 5'd0)) begin
            w_entry.rd_addr  = ret_rd_addr_i;
            w_entry.rd_wdata = ret_rd_wdata_i;
        end
        if (ret_mem_req_i) begin
            w_entry.mem_addr = ret_mem_addr_i;
            if (ret_mem_we_i) begin
                w_entry.mem_wmask = w_lane_mask;
                w_entry.mem_wdata = ret_mem_wdata_i;
            end else begin
                w_entry.mem_rmask = w_lane_mask;
                w_entry.mem_rdata = ret_mem_rdata_i;
            end
        end
    end

    // Storage is reset so the head register reads all-zero out of reset.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_order    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_order  <= r_order + 1'b1;
            end
            if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign rvfi_valid_o     = !w_empty;
    assign rvfi_order_o     = w_head.order;
    assign rvfi_insn_o      = w_head.insn;
    assign rvfi_trap_o      = w_head.trap;
    assign rvfi_intr_o      = w_head.intr;
    assign rvfi_halt_o      = 1'b0;
    assign rvfi_mode_o      = 2'd3;
    assign rvfi_ixl_o       = 2'd1;
    assign rvfi_rs1_addr_o  = w_head.rs1_addr;
    assign rvfi_rs2_addr_o  = w_head.rs2_addr;
    assign rvfi_rs1_rdata_o = w_head.rs1_rdata;
    assign rvfi_rs2_rdata_o = w_head.rs2_rdata;
    assign rvfi_rd_addr_o   = w_head.rd_addr;
    assign rvfi_rd_wdata_o  = w_head.rd_wdata;
    assign rvfi_pc_rdata_o  = w_head.pc_rdata;
    assign rvfi_pc_wdata_o  = w_head.pc_wdata;
    assign rvfi_mem_addr_o  = w_head.mem_addr;
    assign rvfi_mem_rmask_o = w_head.mem_rmask;
    assign rvfi_mem_wmask_o = w_head.mem_wmask;
    assign rvfi_mem_rdata_o = w_head.mem_rdata;
    assign rvfi_mem_wdata_o = w_head.mem_wdata;

    assign level_o    = LVL_W'(r_wr_ptr - r_rd_ptr);
    assign overflow_o = r_overflow;

endmodule
